expr_postfix_sched: RTL and testbench
=====================================

// Module: expr_postfix_sched
// PURPOSE
//  Hardware shunting-yard scheduler for the expression front end.
//  - Consumes an infix token stream (numbers, binary ops, parens, EOF) and emits it in postfix order.
//  - Sequences operator pops from an internal operator stack using the compiler's precedence levels.
//  - Downstream node-builder or evaluator sees operands before their operator.
// PARAMETERS
//  DATA_W  32  width of numeric token payload
//  DEPTH   16  operator-stack entries (ops + open parens); power of 2 not required
// PORTS
//  clk          in   1       single clock, all state on rising edge
//  rst_n        in   1       asynchronous active-low reset
//  tok_valid    in   1       input token valid
//  tok_ready    out  1       input token accepted when tok_valid & tok_ready
//  tok_kind     in   3       0 NUM, 1 OP, 2 LPAREN, 3 RPAREN, 4 EOF; 5-7 illegal
//  tok_op       in   4       op code when kind=OP
//                            0 ASSIGN, 1 EQ, 2 NE, 3 LT, 4 LE, 5 GT, 6 GE,
//                            7 ADD, 8 SUB, 9 MUL, 10 DIV; 11-15 illegal
//  tok_val      in   DATA_W  number payload when kind=NUM
//  out_valid    out  1       postfix item valid
//  out_ready    in   1       downstream accepts item
//  out_is_op    out  1       1 = operator item, 0 = number item
//  out_op       out  4       op code; 4'hF = END marker
//  out_val      out  DATA_W  number payload (0 on op items)
//  out_last     out  1       high only with the END marker
//  busy         out  1       FSM not in ACCEPT or output item pending
//  err          out  1       sticky error flag
//  err_code     out  3       0 none, 1 stack overflow, 2 unmatched ')',
//                            3 unmatched '(', 4 illegal kind/op
// BEHAVIOUR
//  Reset values
//  - All outputs 0 (tok_ready=0 during reset); stack empty; FSM in ACCEPT.
//  Output register
//  - Single registered output slot; "slot free" = !out_valid | out_ready.
//  - out_* held stable while out_valid & !out_ready.
//  Precedence and associativity
//  - ASSIGN=0, EQ/NE=1, LT..GE=2, ADD/SUB=3, MUL/DIV=4.
//  - ASSIGN is right-associative; all other ops are left-associative.
//  - LPAREN on the stack is a barrier and is never popped by precedence.
//  FSM states
//  - ACCEPT
//    - tok_ready = slot free.
//    - NUM: load output slot next cycle (latency 1: accept at N -> out_valid at N+1).
//    - OP: latch into pending; go to POP_PREC.
//    - LPAREN: push (full -> ERROR 1); stay in ACCEPT.
//    - RPAREN: go to POP_PAREN.
//    - EOF: go to FLUSH.
//    - Illegal kind/op: ERROR 4.
//  - POP_PREC (tok_ready=0)
//    - Pop condition: stack non-empty, top not LPAREN, and top.prec >= pend.prec
//      (> for ASSIGN), and slot free.
//    - When the pop condition holds: pop top into output slot, one per cycle.
//    - When it no longer holds: push pending (full -> ERROR 1) and return to ACCEPT.
//    - Stall cycles with slot busy do not change state.
//  - POP_PAREN
//    - Top is op: pop to output when slot free.
//    - Top is LPAREN: discard it in one cycle and return to ACCEPT.
//    - Stack empty: ERROR 2.
//  - FLUSH
//    - Pop ops to output, one per cycle.
//    - LPAREN found: ERROR 3.
//    - Stack empty and slot free: emit END (out_is_op=1, out_op=F, out_last=1) and return to ACCEPT.
//      The next expression starts clean.
//  - ERROR (terminal until rst_n)
//    - err=1; err_code latched on entry.
//    - tok_ready=0; out_valid forced 0 (a pending item is dropped).
//  Simultaneous events
//  - Output drain and new load occur in the same cycle when out_ready=1.
//  - Push and pop never occur in the same cycle.
//  Other
//  - busy=0 only in ACCEPT with out_valid=0.
//  - Async reset mid-expression discards stack and pending output immediately.
// TESTING
//  1. NUM1 OP+ NUM2 OP* NUM3 EOF, out_ready=1 -> 1,2,3,*,+,END; out_last only on END.
//  2. (NUM1 + NUM2) * NUM3 EOF -> 1,2,+,3,*,END; stack empty afterwards.
//  3. NUM7 = NUM8 = NUM5 EOF -> 7,8,5,=,=,END (right-assoc);
//     NUM9 - NUM4 - NUM1 EOF -> 9,4,-,1,-,END (left-assoc).
//  4. Backpressure: out_ready=0 for 5 cycles mid-stream -> out_* stable, tok_ready=0,
//     no item lost or duplicated.
//  5. Errors:
//     - RPAREN first -> err_code 2.
//     - DEPTH=4 with five LPARENs -> err_code 1 on the 5th.
//     - LPAREN NUM1 EOF -> err_code 3.
//     - tok_op=12 -> err_code 4.
//     - In all cases tok_ready stays 0 until rst_n.
//  6. Assert rst_n low mid-FLUSH -> all outputs 0 asynchronously; a fresh expression then parses correctly.

Source files
------------

// File: rtl/expr_postfix_sched.sv
// Shunting-yard scheduler: converts an infix token stream into postfix order.
// Operators wait on an internal stack and are released by precedence, by a
// closing paren, or at EOF. Results leave through a single registered output
// slot with a valid/ready handshake. An END marker closes each expression.
module expr_postfix_sched #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tok_valid,
  output logic              tok_ready,
  input  logic [2:0]        tok_kind,
  input  logic [3:0]        tok_op,
  input  logic [DATA_W-1:0] tok_val,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_is_op,
  output logic [3:0]        out_op,
  output logic [DATA_W-1:0] out_val,
  output logic              out_last,
  output logic              busy,
  output logic              err,
  output logic [2:0]        err_code
);

  localparam int SP_W  = $clog2(DEPTH + 1);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [SP_W-1:0] SP_FULL = SP_W'(DEPTH);
  localparam logic [SP_W-1:0] SP_ONE  = SP_W'(1);

  localparam logic [2:0] K_NUM    = 3'd0;
  localparam logic [2:0] K_OP     = 3'd1;
  localparam logic [2:0] K_LPAREN = 3'd2;
  localparam logic [2:0] K_RPAREN = 3'd3;
  localparam logic [2:0] K_EOF    = 3'd4;

  localparam logic [3:0] OP_ASSIGN = 4'd0;
  localparam logic [3:0] OP_MAX    = 4'd10;
  localparam logic [3:0] OP_END    = 4'hF;

  localparam logic [2:0] E_OVERFLOW  = 3'd1;
  localparam logic [2:0] E_UNMATCH_R = 3'd2;
  localparam logic [2:0] E_UNMATCH_L = 3'd3;
  localparam logic [2:0] E_ILLEGAL   = 3'd4;

  typedef enum logic [2:0] {
    S_ACCEPT,
    S_POP_PREC,
    S_POP_PAREN,
    S_FLUSH,
    S_ERROR
  } state_e;

  typedef struct packed {
    logic       is_lparen;
    logic [3:0] op;
  } stk_ent_t;

  // Binding strength of each operator; higher binds tighter.
  function automatic logic [2:0] prec(input logic [3:0] op);
    logic [2:0] p;
    case (op)
      4'd0:                    p = 3'd0;
      4'd1, 4'd2:              p = 3'd1;
      4'd3, 4'd4, 4'd5, 4'd6:  p = 3'd2;
      4'd7, 4'd8:              p = 3'd3;
      default:                 p = 3'd4;
    endcase
    return p;
  endfunction

  state_e            state_q, state_d;
  logic [SP_W-1:0]   sp_q, sp_d;
  logic [3:0]        pend_q, pend_d;
  logic              out_valid_q, out_valid_d;
  logic              out_is_op_q, out_is_op_d;
  logic [3:0]        out_op_q, out_op_d;
  logic [DATA_W-1:0] out_val_q, out_val_d;
  logic              out_last_q, out_last_d;
  logic              err_q, err_d;
  logic [2:0]        err_code_q, err_code_d;
  logic              run_q;

  stk_ent_t          stack_mem [DEPTH];
  logic              push_en;
  stk_ent_t          push_ent;
  logic [IDX_W-1:0]  push_idx;
  logic [IDX_W-1:0]  top_idx;
  stk_ent_t          top_ent;

  logic slot_free, stk_empty, stk_full, prec_pop;
  logic ld_num, ld_pop, ld_end, do_pop, raise_err;
  logic [2:0] err_sel;

  assign slot_free = !out_valid_q || out_ready;
  assign stk_empty = (sp_q == '0);
  assign stk_full  = (sp_q == SP_FULL);
  assign push_idx  = IDX_W'(sp_q);
  assign top_idx   = IDX_W'(sp_q - SP_ONE);
  assign top_ent   = stack_mem[top_idx];

  // Top of stack leaves before the pending op if it binds at least as tightly
  // (strictly tighter when the pending op is the right-associative ASSIGN).
  assign prec_pop = !stk_empty && !top_ent.is_lparen &&
                    ((prec(top_ent.op) > prec(pend_q)) ||
                     ((prec(top_ent.op) == prec(pend_q)) && (pend_q != OP_ASSIGN)));

  // Next-state, stack control and output-slot update.
  always_comb begin
    // NOTE: every signal written here gets a default first so no latch is inferred.
    state_d    = state_q;
    sp_d       = sp_q;
    pend_d     = pend_q;
    err_d      = err_q;
    err_code_d = err_code_q;
    push_en    = 1'b0;
    push_ent   = '0;
    tok_ready  = 1'b0;
    ld_num     = 1'b0;
    ld_pop     = 1'b0;
    ld_end     = 1'b0;
    do_pop     = 1'b0;
    raise_err  = 1'b0;
    err_sel    = '0;

    // A drained slot clears; a load below overrides it in the same cycle.
    out_valid_d = out_valid_q;
    out_is_op_d = out_is_op_q;
    out_op_d    = out_op_q;
    out_val_d   = out_val_q;
    out_last_d  = out_last_q;
    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
      out_is_op_d = 1'b0;
      out_op_d    = '0;
      out_val_d   = '0;
      out_last_d  = 1'b0;
    end

    case (state_q)
      S_ACCEPT: begin
        tok_ready = run_q && slot_free;
        if (tok_valid && tok_ready) begin
          case (tok_kind)
            K_NUM: ld_num = 1'b1;
            K_OP: begin
              if (tok_op > OP_MAX) begin
                raise_err = 1'b1;
                err_sel   = E_ILLEGAL;
              end else begin
                pend_d  = tok_op;
                state_d = S_POP_PREC;
              end
            end
            K_LPAREN: begin
              if (stk_full) begin
                raise_err = 1'b1;
                err_sel   = E_OVERFLOW;
              end else begin
                push_en            = 1'b1;
                push_ent.is_lparen = 1'b1;
              end
            end
            K_RPAREN: state_d = S_POP_PAREN;
            K_EOF:    state_d = S_FLUSH;
            default: begin
              raise_err = 1'b1;
              err_sel   = E_ILLEGAL;
            end
          endcase
        end
      end
      S_POP_PREC: begin
        if (prec_pop) begin
          if (slot_free) begin
            ld_pop = 1'b1;
            do_pop = 1'b1;
          end
        end else if (stk_full) begin
          raise_err = 1'b1;
          err_sel   = E_OVERFLOW;
        end else begin
          push_en     = 1'b1;
          push_ent.op = pend_q;
          state_d     = S_ACCEPT;
        end
      end
      S_POP_PAREN: begin
        if (stk_empty) begin
          raise_err = 1'b1;
          err_sel   = E_UNMATCH_R;
        end else if (top_ent.is_lparen) begin
          do_pop  = 1'b1;
          state_d = S_ACCEPT;
        end else if (slot_free) begin
          ld_pop = 1'b1;
          do_pop = 1'b1;
        end
      end
      S_FLUSH: begin
        if (stk_empty) begin
          if (slot_free) begin
            ld_end  = 1'b1;
            state_d = S_ACCEPT;
          end
        end else if (top_ent.is_lparen) begin
          raise_err = 1'b1;
          err_sel   = E_UNMATCH_L;
        end else if (slot_free) begin
          ld_pop = 1'b1;
          do_pop = 1'b1;
        end
      end
      S_ERROR: ;
      default: state_d = S_ERROR;
    endcase

    if (ld_num) begin
      out_valid_d = 1'b1;
      out_is_op_d = 1'b0;
      out_op_d    = '0;
      out_val_d   = tok_val;
      out_last_d  = 1'b0;
    end
    if (ld_pop) begin
      out_valid_d = 1'b1;
      out_is_op_d = 1'b1;
      out_op_d    = top_ent.op;
      out_val_d   = '0;
      out_last_d  = 1'b0;
    end
    if (ld_end) begin
      out_valid_d = 1'b1;
      out_is_op_d = 1'b1;
      out_op_d    = OP_END;
      out_val_d   = '0;
      out_last_d  = 1'b1;
    end
    if (do_pop)  sp_d = sp_q - SP_ONE;
    if (push_en) sp_d = sp_q + SP_ONE;

    // Entering or sitting in ERROR drops whatever is in the slot.
    if (raise_err || state_q == S_ERROR) begin
      out_valid_d = 1'b0;
      out_is_op_d = 1'b0;
      out_op_d    = '0;
      out_val_d   = '0;
      out_last_d  = 1'b0;
    end
    if (raise_err) begin
      state_d    = S_ERROR;
      err_d      = 1'b1;
      err_code_d = err_sel;
    end
  end

  // Control and output registers; reset empties the stack and the slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_ACCEPT;
      sp_q        <= '0;
      pend_q      <= '0;
      out_valid_q <= 1'b0;
      out_is_op_q <= 1'b0;
      out_op_q    <= '0;
      out_val_q   <= '0;
      out_last_q  <= 1'b0;
      err_q       <= 1'b0;
      err_code_q  <= '0;
      run_q       <= 1'b0;
    end else begin
      // NOTE: non-blocking so every flop samples the pre-edge values.
      state_q     <= state_d;
      sp_q        <= sp_d;
      pend_q      <= pend_d;
      out_valid_q <= out_valid_d;
      out_is_op_q <= out_is_op_d;
      out_op_q    <= out_op_d;
      out_val_q   <= out_val_d;
      out_last_q  <= out_last_d;
      err_q       <= err_d;
      err_code_q  <= err_code_d;
      run_q       <= 1'b1;
    end
  end

  // Operator stack storage.
  // NOTE: the array has no reset; sp_q alone marks live entries, so clearing it empties the stack.
  always_ff @(posedge clk) begin
    if (push_en) stack_mem[push_idx] <= push_ent;
  end

  assign out_valid = out_valid_q;
  assign out_is_op = out_is_op_q;
  assign out_op    = out_op_q;
  assign out_val   = out_val_q;
  assign out_last  = out_last_q;
  assign err       = err_q;
  assign err_code  = err_code_q;
  assign busy      = (state_q != S_ACCEPT) || out_valid_q;

endmodule

// File: tb/tb_expr_postfix_sched.sv
// Directed bench for expr_postfix_sched: expected postfix items are queued when
// tokens are driven and compared as the DUT hands them over.
module tb_expr_postfix_sched;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 4;

  localparam logic [2:0] K_NUM = 3'd0, K_OP = 3'd1, K_LP = 3'd2, K_RP = 3'd3, K_EOF = 3'd4;
  localparam logic [3:0] O_ASSIGN = 4'd0, O_EQ = 4'd1, O_LT = 4'd3, O_ADD = 4'd7,
                         O_SUB = 4'd8, O_MUL = 4'd9, O_END = 4'hF;

  typedef struct packed {
    logic              is_op;
    logic [3:0]        op;
    logic [DATA_W-1:0] val;
    logic              last;
  } item_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              tok_valid = 1'b0;
  logic              tok_ready;
  logic [2:0]        tok_kind = '0;
  logic [3:0]        tok_op = '0;
  logic [DATA_W-1:0] tok_val = '0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic              out_is_op;
  logic [3:0]        out_op;
  logic [DATA_W-1:0] out_val;
  logic              out_last;
  logic              busy;
  logic              err;
  logic [2:0]        err_code;

  item_t sb[$];
  item_t mon_exp;
  int    vectors = 0;
  int    miscompares = 0;

  expr_postfix_sched #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .tok_valid(tok_valid), .tok_ready(tok_ready), .tok_kind(tok_kind),
    .tok_op(tok_op), .tok_val(tok_val),
    .out_valid(out_valid), .out_ready(out_ready), .out_is_op(out_is_op),
    .out_op(out_op), .out_val(out_val), .out_last(out_last),
    .busy(busy), .err(err), .err_code(err_code)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // Scoreboard: compare each item handed over (valid & ready) against the queue.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      vectors++;
      assert (sb.size() != 0) else begin
        miscompares++;
        $error("FAIL unexpected_item: observed is_op=%0b op=%0d val=%0d, expected no item", out_is_op, out_op, out_val);
      end
      if (sb.size() != 0) begin
        mon_exp = sb.pop_front();
        vectors++;
        assert (out_is_op === mon_exp.is_op) else begin
          miscompares++;
          $error("FAIL item_is_op: observed %0b expected %0b", out_is_op, mon_exp.is_op);
        end
        vectors++;
        assert (out_val === mon_exp.val) else begin
          miscompares++;
          $error("FAIL item_val: observed %0d expected %0d", out_val, mon_exp.val);
        end
        vectors++;
        assert (out_last === mon_exp.last) else begin
          miscompares++;
          $error("FAIL item_last: observed %0b expected %0b", out_last, mon_exp.last);
        end
        if (mon_exp.is_op) begin
          vectors++;
          assert (out_op === mon_exp.op) else begin
            miscompares++;
            $error("FAIL item_op: observed %0d expected %0d", out_op, mon_exp.op);
          end
        end
      end
    end
  end

  task automatic check(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic e_num(input logic [DATA_W-1:0] v);
    item_t it;
    it.is_op = 1'b0; it.op = '0; it.val = v; it.last = 1'b0;
    sb.push_back(it);
  endtask

  task automatic e_op(input logic [3:0] o);
    item_t it;
    it.is_op = 1'b1; it.op = o; it.val = '0; it.last = 1'b0;
    sb.push_back(it);
  endtask

  task automatic e_end();
    item_t it;
    it.is_op = 1'b1; it.op = O_END; it.val = '0; it.last = 1'b1;
    sb.push_back(it);
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [2:0] kind, input logic [3:0] op, input logic [DATA_W-1:0] val);
    int n;
    tok_kind = kind; tok_op = op; tok_val = val; tok_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!tok_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    assert (n < 200) else begin
      miscompares++;
      $error("FAIL send_timeout: tok_ready observed 0 for %0d cycles, expected 1", n);
    end
    @(posedge clk); #2;
    tok_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    @(negedge clk);
    while ((sb.size() != 0 || busy) && n < 500) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    assert (n < 500) else begin
      miscompares++;
      $error("FAIL drain_timeout: %0d items outstanding busy=%0b, expected 0 and 0", sb.size(), busy);
    end
    @(posedge clk); #2;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; tok_valid = 1'b0; out_ready = 1'b1;
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #2;
  endtask

  task automatic expect_error(input string tag, input logic [2:0] code);
    repeat (3) @(negedge clk);
    check({tag, "_err"}, err, 1);
    check({tag, "_code"}, err_code, code);
    check({tag, "_valid"}, out_valid, 0);
    check({tag, "_busy"}, busy, 1);
    tok_kind = K_NUM; tok_val = 99; tok_valid = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check({tag, "_ready"}, tok_ready, 0);
    end
    tok_valid = 1'b0;
    check({tag, "_sb_empty"}, sb.size(), 0);
    @(posedge clk); #2;
  endtask

  initial begin
    // Reset values
    #12;
    check("rst_tok_ready", tok_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_last", out_last, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    check("rst_err_code", err_code, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #2;

    // 1 + 2 * 3
    e_num(1); e_num(2); e_num(3); e_op(O_MUL); e_op(O_ADD); e_end();
    send(K_NUM, 0, 1); send(K_OP, O_ADD, 0); send(K_NUM, 0, 2);
    send(K_OP, O_MUL, 0); send(K_NUM, 0, 3); send(K_EOF, 0, 0);
    wait_drain();

    // (1 + 2) * 3, then a bare EOF proves the stack was left empty
    e_num(1); e_num(2); e_op(O_ADD); e_num(3); e_op(O_MUL); e_end();
    send(K_LP, 0, 0); send(K_NUM, 0, 1); send(K_OP, O_ADD, 0); send(K_NUM, 0, 2);
    send(K_RP, 0, 0); send(K_OP, O_MUL, 0); send(K_NUM, 0, 3); send(K_EOF, 0, 0);
    wait_drain();
    e_end();
    send(K_EOF, 0, 0);
    wait_drain();

    // 7 = 8 = 5 (right-associative)
    e_num(7); e_num(8); e_num(5); e_op(O_ASSIGN); e_op(O_ASSIGN); e_end();
    send(K_NUM, 0, 7); send(K_OP, O_ASSIGN, 0); send(K_NUM, 0, 8);
    send(K_OP, O_ASSIGN, 0); send(K_NUM, 0, 5); send(K_EOF, 0, 0);
    wait_drain();

    // 9 - 4 - 1 (left-associative)
    e_num(9); e_num(4); e_op(O_SUB); e_num(1); e_op(O_SUB); e_end();
    send(K_NUM, 0, 9); send(K_OP, O_SUB, 0); send(K_NUM, 0, 4);
    send(K_OP, O_SUB, 0); send(K_NUM, 0, 1); send(K_EOF, 0, 0);
    wait_drain();

    // 1 < 2 == 3 (tighter comparison pops before equality)
    e_num(1); e_num(2); e_op(O_LT); e_num(3); e_op(O_EQ); e_end();
    send(K_NUM, 0, 1); send(K_OP, O_LT, 0); send(K_NUM, 0, 2);
    send(K_OP, O_EQ, 0); send(K_NUM, 0, 3); send(K_EOF, 0, 0);
    wait_drain();

    // Backpressure on a number item, with a token offered during the stall
    e_num(11); e_num(12); e_op(O_ADD); e_end();
    out_ready = 1'b0;
    send(K_NUM, 0, 11);
    tok_kind = K_OP; tok_op = O_ADD; tok_valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("bp_num_valid", out_valid, 1);
      check("bp_num_val", out_val, 11);
      check("bp_num_is_op", out_is_op, 0);
      check("bp_num_tok_ready", tok_ready, 0);
    end
    @(posedge clk); #2;
    out_ready = 1'b1;
    send(K_OP, O_ADD, 0); send(K_NUM, 0, 12); send(K_EOF, 0, 0);
    wait_drain();

    // Backpressure on an operator item while flushing
    e_num(3); e_num(4); e_op(O_MUL); e_end();
    send(K_NUM, 0, 3); send(K_OP, O_MUL, 0); send(K_NUM, 0, 4); send(K_EOF, 0, 0);
    out_ready = 1'b0;
    @(posedge clk); #2;
    repeat (5) begin
      @(negedge clk);
      check("bp_op_valid", out_valid, 1);
      check("bp_op_is_op", out_is_op, 1);
      check("bp_op_op", out_op, O_MUL);
      check("bp_op_last", out_last, 0);
      check("bp_op_busy", busy, 1);
    end
    @(posedge clk); #2;
    out_ready = 1'b1;
    wait_drain();

    // Error: ')' with nothing open
    do_reset();
    send(K_RP, 0, 0);
    expect_error("err_rparen", 3'd2);

    // Error: one more '(' than the stack holds
    do_reset();
    repeat (DEPTH + 1) send(K_LP, 0, 0);
    expect_error("err_overflow", 3'd1);

    // Error: '(' left open at EOF
    do_reset();
    e_num(1);
    send(K_LP, 0, 0); send(K_NUM, 0, 1); send(K_EOF, 0, 0);
    expect_error("err_lparen", 3'd3);

    // Error: illegal op code, and separately an illegal kind
    do_reset();
    send(K_OP, 4'd12, 0);
    expect_error("err_op", 3'd4);
    do_reset();
    send(3'd5, 0, 0);
    expect_error("err_kind", 3'd4);

    // Asynchronous reset while FLUSH holds an operator in the slot
    do_reset();
    e_num(1); e_num(2);
    send(K_NUM, 0, 1); send(K_OP, O_ADD, 0); send(K_NUM, 0, 2); send(K_EOF, 0, 0);
    out_ready = 1'b0;
    @(posedge clk); #2;
    check("flush_pre_valid", out_valid, 1);
    check("flush_pre_busy", busy, 1);
    check("flush_pre_sb_empty", sb.size(), 0);
    rst_n = 1'b0;
    #1;
    check("async_out_valid", out_valid, 0);
    check("async_out_is_op", out_is_op, 0);
    check("async_out_op", out_op, 0);
    check("async_out_last", out_last, 0);
    check("async_busy", busy, 0);
    check("async_tok_ready", tok_ready, 0);
    check("async_err", err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #2;
    e_num(5); e_num(6); e_op(O_MUL); e_end();
    send(K_NUM, 0, 5); send(K_OP, O_MUL, 0); send(K_NUM, 0, 6); send(K_EOF, 0, 0);
    wait_drain();
    check("final_err", err, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
